// File: rtl/snitch_icache_pkg.sv
// Shared instruction-cache types: per-port L0 event pulses and the
// performance-counter selector used by the counter read port.
package snitch_icache_pkg;

  typedef struct packed {
    logic l0_miss;
    logic l0_hit;
    logic l0_prefetch;
    logic l0_double_hit;
    logic l0_stall;
  } icache_events_t;

  typedef enum logic [2:0] {
    MISS       = 3'd0,
    HIT        = 3'd1,
    PREFETCH   = 3'd2,
    DOUBLE_HIT = 3'd3,
    STALL      = 3'd4,
    CYCLES     = 3'd5
  } perf_sel_e;

  localparam int unsigned NrPerfCounters = 6;
  localparam int unsigned NrEventTypes   = 5;

endpackage

// File: rtl/snitch_icache_perf_counters_if.sv
// Valid/ready read port of the icache performance counters.
interface snitch_icache_perf_counters_if #(
  parameter int unsigned CNT_W = 32
) ();

  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_addr;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [CNT_W-1:0] rsp_data;
  logic             rsp_ovf;
  logic             rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_ovf, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_ovf, rsp_err
  );

endinterface

// File: rtl/snitch_icache_sat_counter.sv
// Saturating up-counter with sticky overflow flag; clear has priority.
module snitch_icache_sat_counter #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned INC_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [INC_W-1:0] inc_i,
  output logic [CNT_W-1:0] count_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W:0]   sum;

  always_comb begin
    sum     = {1'b0, count_q} + (CNT_W+1)'(inc_i);
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear_i) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (en_i) begin
      if (sum[CNT_W]) begin
        count_d = '1;
        ovf_d   = 1'b1;
      end else begin
        count_d = sum[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/snitch_icache_perf_counters.sv
// Sums per-port L0 cache events into saturating counters plus an enabled-cycle
// counter, readable through a valid/ready port with a registered response.
module snitch_icache_perf_counters
  import snitch_icache_pkg::*;
#(
  parameter int unsigned NR_FETCH_PORTS = 2,
  parameter int unsigned CNT_W          = 32,
  parameter type         EVT_T          = snitch_icache_pkg::icache_events_t
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  EVT_T [NR_FETCH_PORTS-1:0] events_i,
  input  logic                      enable_i,
  input  logic                      clear_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [2:0]                req_addr_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [CNT_W-1:0]          rsp_data_o,
  output logic                      rsp_ovf_o,
  output logic                      rsp_err_o
);

  localparam int unsigned INC_W = $clog2(NR_FETCH_PORTS + 1);

  EVT_T [NR_FETCH_PORTS-1:0] evt_q, evt_d;
  logic                      en_q, en_d;

  // Clear also flushes the sampling stage so no in-flight event survives it.
  always_comb begin
    evt_d = clear_i ? '0 : events_i;
    en_d  = clear_i ? 1'b0 : enable_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      evt_q <= '0;
      en_q  <= 1'b0;
    end else begin
      evt_q <= evt_d;
      en_q  <= en_d;
    end
  end

  logic [NrEventTypes-1:0][INC_W-1:0] inc;

  always_comb begin
    inc = '0;
    for (int unsigned p = 0; p < NR_FETCH_PORTS; p++) begin
      inc[MISS]       = inc[MISS]       + INC_W'(evt_q[p].l0_miss);
      inc[HIT]        = inc[HIT]        + INC_W'(evt_q[p].l0_hit);
      inc[PREFETCH]   = inc[PREFETCH]   + INC_W'(evt_q[p].l0_prefetch);
      inc[DOUBLE_HIT] = inc[DOUBLE_HIT] + INC_W'(evt_q[p].l0_double_hit);
      inc[STALL]      = inc[STALL]      + INC_W'(evt_q[p].l0_stall);
    end
  end

  logic [NrPerfCounters-1:0][CNT_W-1:0] cnt;
  logic [NrPerfCounters-1:0]            ovf;

  for (genvar k = 0; k < NrEventTypes; k++) begin : gen_evt_cnt
    snitch_icache_sat_counter #(
      .CNT_W (CNT_W),
      .INC_W (INC_W)
    ) i_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .en_i    (en_q),
      .inc_i   (inc[k]),
      .count_o (cnt[k]),
      .ovf_o   (ovf[k])
    );
  end

  snitch_icache_sat_counter #(
    .CNT_W (CNT_W),
    .INC_W (1)
  ) i_cycle_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .en_i    (en_q),
    .inc_i   (1'b1),
    .count_o (cnt[CYCLES]),
    .ovf_o   (ovf[CYCLES])
  );

  logic             rsp_valid_q, rsp_valid_d;
  logic [CNT_W-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic             rsp_err_q, rsp_err_d;
  logic             req_accept;

  assign req_ready_o = !rsp_valid_q || rsp_ready_i;
  assign req_accept  = req_valid_i && req_ready_o;

  // Captures the pre-update counter value, so a read in a clear cycle sees old data.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_err_d   = rsp_err_q;
    if (rsp_valid_q && rsp_ready_i) rsp_valid_d = 1'b0;
    if (req_accept) begin
      rsp_valid_d = 1'b1;
      if (req_addr_i < 3'(NrPerfCounters)) begin
        rsp_data_d = cnt[req_addr_i];
        rsp_ovf_d  = ovf[req_addr_i];
        rsp_err_d  = 1'b0;
      end else begin
        rsp_data_d = '0;
        rsp_ovf_d  = 1'b0;
        rsp_err_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_ovf_o   = rsp_ovf_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_snitch_icache_perf_counters.sv
// Directed bench for snitch_icache_perf_counters: a 32-bit and an 8-bit
// instance share stimulus; expected values are hand-computed.
module tb_snitch_icache_perf_counters;
  import snitch_icache_pkg::*;

  localparam int unsigned NP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  icache_events_t [NP-1:0] ev;
  logic enable, clear;

  snitch_icache_perf_counters_if #(.CNT_W(32)) bus ();

  logic       req_ready8, rsp_valid8, rsp_ovf8, rsp_err8;
  logic [7:0] rsp_data8;

  snitch_icache_perf_counters #(.NR_FETCH_PORTS(NP), .CNT_W(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .events_i    (ev),
    .enable_i    (enable),
    .clear_i     (clear),
    .req_valid_i (bus.req_valid),
    .req_ready_o (bus.req_ready),
    .req_addr_i  (bus.req_addr),
    .rsp_valid_o (bus.rsp_valid),
    .rsp_ready_i (bus.rsp_ready),
    .rsp_data_o  (bus.rsp_data),
    .rsp_ovf_o   (bus.rsp_ovf),
    .rsp_err_o   (bus.rsp_err)
  );

  snitch_icache_perf_counters #(.NR_FETCH_PORTS(NP), .CNT_W(8)) dut8 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .events_i    (ev),
    .enable_i    (enable),
    .clear_i     (clear),
    .req_valid_i (bus.req_valid),
    .req_ready_o (req_ready8),
    .req_addr_i  (bus.req_addr),
    .rsp_valid_o (rsp_valid8),
    .rsp_ready_i (bus.rsp_ready),
    .rsp_data_o  (rsp_data8),
    .rsp_ovf_o   (rsp_ovf8),
    .rsp_err_o   (rsp_err8)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  addr;
    logic [63:0] data;
    logic        ovf;
    logic        err;
  } vec_t;

  vec_t tbl[8];

  logic [63:0] rd_d, rd_d8;
  logic        rd_o, rd_e, rd_o8;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // One read transaction; leaves the response consumed and the port idle.
  task automatic do_read(input logic [2:0] a);
    int unsigned n = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.rsp_ready = 1'b1;
    while (!bus.req_ready && n < 20) begin
      tick();
      n++;
    end
    chk("req_ready_wait", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    chk("rsp_valid", bus.rsp_valid, 1);
    rd_d  = bus.rsp_data;
    rd_o  = bus.rsp_ovf;
    rd_e  = bus.rsp_err;
    rd_d8 = 64'(rsp_data8);
    rd_o8 = rsp_ovf8;
    tick();
  endtask

  task automatic read_chk(input string name, input logic [2:0] a, input logic [63:0] d,
                          input logic o, input logic e);
    do_read(a);
    chk({name, "_data"}, rd_d, d);
    chk({name, "_ovf"}, rd_o, o);
    chk({name, "_err"}, rd_e, e);
  endtask

  task automatic run_table(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      read_chk($sformatf("%s[%0d]", name, i), tbl[i].addr, tbl[i].data, tbl[i].ovf, tbl[i].err);
    end
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    ev            = '0;
    enable        = 1'b0;
    clear         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_ovf", bus.rsp_ovf, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_rsp_valid8", rsp_valid8, 0);
    rst_n = 1'b1;
    tick();

    // Both ports hit for 10 cycles, then back-to-back reads of hit and cycles
    enable = 1'b1;
    ev[0].l0_hit = 1'b1;
    ev[1].l0_hit = 1'b1;
    repeat (10) tick();
    ev = '0;
    repeat (2) tick();
    bus.req_valid = 1'b1;
    bus.req_addr  = 3'd1;
    bus.rsp_ready = 1'b1;
    tick();
    chk("hit_data", bus.rsp_data, 20);
    chk("hit_ovf", bus.rsp_ovf, 0);
    chk("hit_err", bus.rsp_err, 0);
    chk("b2b_req_ready", bus.req_ready, 1);
    bus.req_addr = 3'd5;
    tick();
    chk("cycles_data", bus.rsp_data, 12);
    chk("b2b_rsp_valid", bus.rsp_valid, 1);
    bus.req_valid = 1'b0;
    enable = 1'b0;
    tick();
    chk("idle_rsp_valid", bus.rsp_valid, 0);

    // Full counter map with counting frozen
    tbl[0] = '{3'd0, 64'd0,  1'b0, 1'b0};
    tbl[1] = '{3'd1, 64'd20, 1'b0, 1'b0};
    tbl[2] = '{3'd2, 64'd0,  1'b0, 1'b0};
    tbl[3] = '{3'd3, 64'd0,  1'b0, 1'b0};
    tbl[4] = '{3'd4, 64'd0,  1'b0, 1'b0};
    tbl[5] = '{3'd5, 64'd14, 1'b0, 1'b0};
    tbl[6] = '{3'd6, 64'd0,  1'b0, 1'b1};
    tbl[7] = '{3'd7, 64'd0,  1'b0, 1'b1};
    run_table(8, "map");

    // Invalid address with response held for 5 cycles
    bus.req_valid = 1'b1;
    bus.req_addr  = 3'd6;
    bus.rsp_ready = 1'b0;
    tick();
    bus.req_addr = 3'd1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_rsp_valid", bus.rsp_valid, 1);
      chk("hold_rsp_err", bus.rsp_err, 1);
      chk("hold_rsp_data", bus.rsp_data, 0);
      chk("hold_req_ready", bus.req_ready, 0);
      if (i < 4) tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("release_req_ready", bus.req_ready, 1);
    tick();
    chk("release_rsp_valid", bus.rsp_valid, 1);
    chk("release_rsp_data", bus.rsp_data, 20);
    chk("release_rsp_err", bus.rsp_err, 0);
    bus.req_valid = 1'b0;
    tick();
    chk("release_idle", bus.rsp_valid, 0);

    // enable_i=0 with every event asserted
    clear_pulse();
    ev = '1;
    repeat (8) tick();
    ev = '0;
    repeat (2) tick();
    for (int i = 0; i < 6; i++) tbl[i] = '{3'(i), 64'd0, 1'b0, 1'b0};
    run_table(6, "disabled");

    // Clear discards both sampled and in-flight events; read in clear cycle sees old value
    enable = 1'b1;
    ev[0].l0_hit = 1'b1;
    ev[1].l0_hit = 1'b1;
    tick();
    ev = '0;
    ev[0].l0_stall = 1'b1;
    ev[1].l0_stall = 1'b1;
    tick();
    clear = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 3'd1;
    bus.rsp_ready = 1'b1;
    tick();
    chk("clear_cycle_read", bus.rsp_data, 2);
    clear = 1'b0;
    ev = '0;
    bus.req_valid = 1'b0;
    repeat (2) tick();
    read_chk("clear_stall", 3'd4, 64'd0, 1'b0, 1'b0);
    read_chk("clear_hit", 3'd1, 64'd0, 1'b0, 1'b0);

    // Stall counting after clear, then a mixed pattern across event types
    ev[0].l0_stall = 1'b1;
    ev[1].l0_stall = 1'b1;
    tick();
    ev = '0;
    ev[0].l0_miss       = 1'b1;
    ev[0].l0_prefetch   = 1'b1;
    ev[1].l0_prefetch   = 1'b1;
    ev[1].l0_double_hit = 1'b1;
    repeat (3) tick();
    ev = '0;
    enable = 1'b0;
    repeat (2) tick();
    tbl[0] = '{3'd0, 64'd3, 1'b0, 1'b0};
    tbl[1] = '{3'd1, 64'd0, 1'b0, 1'b0};
    tbl[2] = '{3'd2, 64'd6, 1'b0, 1'b0};
    tbl[3] = '{3'd3, 64'd3, 1'b0, 1'b0};
    tbl[4] = '{3'd4, 64'd2, 1'b0, 1'b0};
    run_table(5, "mixed");

    // Saturation on the 8-bit instance: exactly 255, then past it
    enable = 1'b1;
    clear_pulse();
    ev[0].l0_miss = 1'b1;
    repeat (255) tick();
    ev = '0;
    repeat (2) tick();
    do_read(3'd0);
    chk("sat255_d8", rd_d8, 255);
    chk("sat255_ovf8", rd_o8, 0);
    ev[0].l0_miss = 1'b1;
    repeat (45) tick();
    ev = '0;
    repeat (2) tick();
    do_read(3'd0);
    chk("sat300_d8", rd_d8, 255);
    chk("sat300_ovf8", rd_o8, 1);
    chk("sat300_d32", rd_d, 300);
    chk("sat300_ovf32", rd_o, 0);
    do_read(3'd5);
    chk("satcyc_d8", rd_d8, 255);
    chk("satcyc_ovf8", rd_o8, 1);
    clear_pulse();
    do_read(3'd0);
    chk("postclr_d8", rd_d8, 0);
    chk("postclr_ovf8", rd_o8, 0);
    chk("postclr_d32", rd_d, 0);

    // Asynchronous reset with a pending response
    ev[0].l0_hit = 1'b1;
    ev[1].l0_hit = 1'b1;
    repeat (2) tick();
    ev = '0;
    enable = 1'b0;
    repeat (2) tick();
    bus.req_valid = 1'b1;
    bus.req_addr  = 3'd1;
    bus.rsp_ready = 1'b0;
    tick();
    chk("prerst_rsp_valid", bus.rsp_valid, 1);
    chk("prerst_rsp_data", bus.rsp_data, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    chk("midrst_rsp_data", bus.rsp_data, 0);
    chk("midrst_req_ready", bus.req_ready, 1);
    bus.req_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) tbl[i] = '{3'(i), 64'd0, 1'b0, 1'b0};
    run_table(6, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snitch_icache_perf_counters.md
Name: snitch_icache_perf_counters

Overview:
- Downstream consumer of the instruction cache's per-fetch-port L0 event vectors: miss, hit, prefetch, double_hit and stall.
- Sums each event type across all fetch ports into saturating counters, and also counts enabled cycles.
- Exposes all counters through a valid/ready read port with a registered response, for the cluster peripheral or debug interconnect.

Parameters:
- NR_FETCH_PORTS, 2, number of fetch ports; width of the event vector array.
- CNT_W, 32, width of each counter (8..64).
- EVT_T, snitch_icache_pkg::icache_events_t, per-port event struct type.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- events_i  in  NR_FETCH_PORTS x EVT_T  per-port event pulses; one bit per event per cycle.
- enable_i  in  1  counting enable; sampled together with events_i.
- clear_i  in  1  synchronous clear pulse for all counters and overflow flags.
- req_valid_i  in  1  read request valid.
- req_ready_o  out  1  read request ready.
- req_addr_i  in  3  counter select: 0 miss, 1 hit, 2 prefetch, 3 double_hit, 4 stall, 5 cycles.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response ready.
- rsp_data_o  out  CNT_W  counter value.
- rsp_ovf_o  out  1  sticky overflow flag of the selected counter.
- rsp_err_o  out  1  req_addr_i was 6 or 7.

Behaviour:
- Reset values: all counters, overflow flags and pipeline registers are 0; rsp_valid_o=0, rsp_data_o=0, rsp_ovf_o=0, rsp_err_o=0.
- req_ready_o is 1 during reset, because it is derived from rsp_valid_o=0.
- Stage 1 registers events_i and enable_i (evt_q, en_q).
- Stage 2: for each event type k, popcount over the ports gives inc_k, with width clog2(NR_FETCH_PORTS+1). When en_q=1, cnt_k <= sat(cnt_k + inc_k).
- The cycle counter adds 1 in each cycle with en_q=1.
- Latency: an event present on events_i at cycle t is visible in a read accepted at cycle t+2 or later.
- Saturation: a sum exceeding 2^CNT_W-1 clamps to all-ones and sets ovf_k (sticky). Counters never wrap.
- Clear: while clear_i=1, all counters, ovf flags and evt_q/en_q go to 0 next cycle.
  - Events sampled in the clear cycle are discarded.
  - Events already in evt_q in the clear cycle are discarded.
  - Clear wins over simultaneous increments.
- Read handshake:
  - req_ready_o = !rsp_valid_o || rsp_ready_i.
  - On accept (req_valid_i && req_ready_o), the selected counter value as registered in that cycle, i.e. before the same-cycle update, is captured into the rsp registers. rsp_valid_o=1 the next cycle.
  - Response holds stable until rsp_valid_o && rsp_ready_i.
  - Back-to-back reads give throughput of one per cycle when rsp_ready_i=1.
  - A read accepted in a clear cycle returns the pre-clear value.
- Invalid address (6, 7): rsp_data_o=0, rsp_ovf_o=0, rsp_err_o=1. No state change.
- No state machine beyond the response-valid flag: IDLE (rsp_valid=0) / RESP (rsp_valid=1).
  - IDLE->RESP on accept.
  - RESP->IDLE on rsp_ready_i without a new accept.
  - RESP stays RESP on rsp_ready_i with a new accept.
- Reset mid-operation (rst_ni low): everything returns to reset values asynchronously; any pending response is dropped.
- enable_i=0: events are ignored and no counter changes; reads remain serviced.

Decomposition:
- Add to snitch_icache_pkg:
  - perf_sel_e enum (MISS=0..CYCLES=5).
  - NrPerfCounters=6 constant.
- One natural sub-module: snitch_icache_sat_counter, parameterised by CNT_W and INC_W.
  - Inputs: clear, en, inc.
  - Outputs: count, ovf.
  - Instantiated six times.
- Popcount is local combinational logic.

Test Plan:
- Reset, then NR_FETCH_PORTS=2, enable_i=1, both ports l0_hit=1 for 10 cycles, wait 2 cycles, read addr 1 -> rsp_data_o=20, rsp_ovf_o=0, rsp_err_o=0; read addr 5 -> 12 (enabled cycles counted from the first hit cycle through the read cycle).
- CNT_W=8, port0 l0_miss=1 for 300 cycles -> read addr 0 gives 255 with rsp_ovf_o=1; clear_i pulse then read -> 0, ovf 0.
- clear_i asserted in the same cycle as events_i stall=2'b11, and the previous cycle also had stall=2'b11 -> a read 3 cycles later on addr 4 returns 0.
- Read addr 6 -> rsp_err_o=1, rsp_data_o=0; hold rsp_ready_i=0 for 5 cycles -> response stable and req_ready_o=0 throughout; next request accepted in the cycle rsp_ready_i rises.
- enable_i=0 with all events 1 for 8 cycles -> all six counters read 0.
- Assert rst_ni low while rsp_valid_o=1 and counters are nonzero -> rsp_valid_o=0 immediately; all reads after release return 0.
